// File: rtl/datamem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states,
// access-size decode and default geometry.
package datamem_ctrl_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 9;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StRmwRd,
    StRmwWr,
    StSt
  } state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  // Unlisted codes fall through to word accesses.
  function automatic size_e funct3_size(input logic [2:0] f3);
    case (f3)
      Funct3B, Funct3Bu: return SzByte;
      Funct3H, Funct3Hu: return SzHalf;
      default:           return SzWord;
    endcase
  endfunction

  // Clears the address bits that the access size does not use.
  function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] lo);
    case (sz)
      SzByte:  return lo;
      SzHalf:  return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    return ((sz == SzHalf) && lo[0]) || ((sz == SzWord) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/datamem_ctrl_if.sv
// Core <-> data-memory controller bus. The misalign signal exists only when
// DMEM_MISALIGN_TRAP_EN is defined.
interface datamem_ctrl_if
  import datamem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef
);

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic              misalign;

  modport master (
    output rd, wr, addr, funct3, wr_data,
    input  rd_data, busy, done, misalign
  );

  modport slave (
    input  rd, wr, addr, funct3, wr_data,
    output rd_data, busy, done, misalign
  );
`else
  modport master (
    output rd, wr, addr, funct3, wr_data,
    input  rd_data, busy, done
  );

  modport slave (
    input  rd, wr, addr, funct3, wr_data,
    output rd_data, busy, done
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous read and whole-word write enable.
// Contents are never reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Write when enabled, otherwise register the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_ctrl.sv
// Data-memory controller: byte/half/word loads with sign/zero extension and
// read-modify-write for sub-word stores over a word-wide RAM.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (drop misaligned accesses and
// pulse misalign instead of forcing the low address bits to zero).
module datamem_ctrl
  import datamem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef
) (
  input logic           clk,
  input logic           reset,
  datamem_ctrl_if.slave bus
);

  localparam int unsigned IdxW = ADDR_W - 2;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;

  logic              req;
  logic              trap;
  size_e             req_size;
  size_e             cur_size;
  logic [IdxW-1:0]   mem_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] merged;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        lo,
                                                 input logic [2:0]        f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (funct3_size(f3))
      SzByte:  return f3[2] ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      SzHalf:  return f3[2] ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign req      = bus.rd | bus.wr;
  assign req_size = funct3_size(bus.funct3);
  assign cur_size = funct3_size(funct3_q);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = req && (state_q == StIdle) && is_misaligned(req_size, bus.addr[1:0]);

  // One-cycle pulse for each dropped misaligned request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= trap;
    end
  end

  assign bus.misalign = misalign_q;
`else
  assign trap = 1'b0;
`endif

  // In IDLE the RAM reads the incoming address so a load has data in LD;
  // otherwise it follows the captured request.
  assign mem_idx   = (state_q == StIdle) ? bus.addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
  assign mem_we    = (state_q == StSt) || (state_q == StRmwWr);
  assign mem_wdata = (state_q == StSt) ? wdata_q : merged;

  // Overlay the store lane onto the word fetched in RMW_RD.
  always_comb begin
    merged = mem_rdata;
    case (cur_size)
      SzByte:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SzHalf:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Access sequencer with registered rd_data/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req && !trap) begin
            addr_q   <= {bus.addr[ADDR_W-1:2], align_lo(req_size, bus.addr[1:0])};
            funct3_q <= bus.funct3;
            wdata_q  <= bus.wr_data;
            // A store wins over a simultaneous load.
            if (bus.wr) begin
              if (req_size == SzWord) begin
                state_q <= StSt;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRmwRd;
              end
            end else begin
              state_q <= StLd;
            end
          end
        end
        StLd: begin
          rd_data_q <= load_ext(mem_rdata, addr_q[1:0], funct3_q);
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end
        StRmwRd: begin
          done_q  <= 1'b1;
          state_q <= StRmwWr;
        end
        StRmwWr: state_q <= StIdle;
        StSt:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != StIdle);

  dmem_array #(
    .DATA_W(DATA_W),
    .IDX_W (IdxW)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .idx_i  (mem_idx),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed bench for datamem_ctrl; load results go through an expected-value queue.
module tb_datamem_ctrl;
  import datamem_ctrl_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  datamem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  datamem_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle, return cycles until done (0 if done never rises),
  // then wait until the controller is idle again.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [AW-1:0] a, input logic [31:0] d, input string tag,
                        output int lat);
    bus.rd = rd; bus.wr = wr; bus.funct3 = f3; bus.addr = a; bus.wr_data = d;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    for (int n = 0; n < 8 && bus.busy !== 1'b0; n++) tick();
  endtask

  task automatic store(input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] d,
                       input int exp_lat, input string tag);
    int lat;
    access(1'b0, 1'b1, f3, a, d, tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic load(input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] exp,
                      input string tag);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp);
    access(1'b1, 1'b0, f3, a, 32'h0, tag, lat);
    check({tag, " latency"}, 32'(lat), 32'd2);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " data"}, bus.rd_data, e);
    end
  endtask

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.funct3 = '0; bus.wr_data = '0;
    #1;
    check("reset rd_data", bus.rd_data, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    #22 reset = 1'b1;
    tick();

    // Word store then load.
    store(Funct3W, 9'h010, 32'hDEADBEEF, 1, "sw 010");
    load(Funct3W, 9'h010, 32'hDEADBEEF, "lw 010");

    // Byte merge and half merge.
    store(Funct3W, 9'h020, 32'h11223344, 1, "sw 020");
    store(Funct3B, 9'h021, 32'h000000AA, 2, "sb 021");
    load(Funct3W, 9'h020, 32'h1122AA44, "lw 020");

    // Extension.
    store(Funct3W, 9'h030, 32'h0000F080, 1, "sw 030");
    load(Funct3B, 9'h030, 32'hFFFFFF80, "lb 030");
    load(Funct3Bu, 9'h030, 32'h00000080, "lbu 030");
    load(Funct3H, 9'h030, 32'hFFFFF080, "lh 030");
    load(Funct3Hu, 9'h030, 32'h0000F080, "lhu 030");
    load(Funct3B, 9'h031, 32'hFFFFFFF0, "lb 031");
    store(Funct3H, 9'h032, 32'h0000BEEF, 2, "sh 032");
    load(Funct3W, 9'h030, 32'hBEEFF080, "lw 030 after sh");
    load(3'b111, 9'h030, 32'hBEEFF080, "funct3 111 as word");

    // Simultaneous rd/wr is a store; a request while busy is ignored.
    store(Funct3W, 9'h044, 32'h12345678, 1, "sw 044");
    load(Funct3W, 9'h044, 32'h12345678, "lw 044");
    bus.rd = 1'b1; bus.wr = 1'b1; bus.funct3 = Funct3W; bus.addr = 9'h040; bus.wr_data = 32'h5;
    tick();
    check("rd+wr done in ST", 32'(bus.done), 32'd1);
    check("rd+wr busy in ST", 32'(bus.busy), 32'd1);
    bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = 9'h044; bus.wr_data = 32'h0000CAFE;
    tick();
    bus.wr = 1'b0;
    check("busy req ignored busy", 32'(bus.busy), 32'd0);
    tick();
    check("busy req ignored done", 32'(bus.done), 32'd0);
    check("rd+wr rd_data held", bus.rd_data, 32'h12345678);
    load(Funct3W, 9'h040, 32'h00000005, "lw 040");
    load(Funct3W, 9'h044, 32'h12345678, "lw 044 untouched");

    // Reset during RMW_WR drops the write.
    store(Funct3W, 9'h050, 32'h01020304, 1, "sw 050");
    bus.wr = 1'b1; bus.funct3 = Funct3B; bus.addr = 9'h051; bus.wr_data = 32'hFF;
    tick();
    bus.wr = 1'b0;
    check("rmw_rd done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid-rmw reset done", 32'(bus.done), 32'd0);
    check("mid-rmw reset busy", 32'(bus.busy), 32'd0);
    check("mid-rmw reset rd_data", bus.rd_data, 32'h0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    load(Funct3W, 9'h050, 32'h01020304, "lw 050 after reset");

    // Misaligned accesses.
    store(Funct3W, 9'h060, 32'hA5A50F0F, 1, "sw 060");
`ifdef DMEM_MISALIGN_TRAP_EN
    bus.rd = 1'b1; bus.funct3 = Funct3W; bus.addr = 9'h062;
    tick();
    bus.rd = 1'b0;
    check("misalign pulse", 32'(bus.misalign), 32'd1);
    check("misalign busy", 32'(bus.busy), 32'd0);
    check("misalign done", 32'(bus.done), 32'd0);
    tick();
    check("misalign one cycle", 32'(bus.misalign), 32'd0);
    check("misalign no done", 32'(bus.done), 32'd0);
    check("misalign rd_data held", bus.rd_data, 32'h01020304);
`else
    load(Funct3W, 9'h062, 32'hA5A50F0F, "lw 062 forced");
    load(Funct3H, 9'h063, 32'hFFFFA5A5, "lh 063 forced");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datamem_ctrl.md
DATAMEM_CTRL -- requirements
Module: datamem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits.
REQ-002 Parameter ADDR_W, default 9: byte-address width; array depth is 2^(ADDR_W-2) words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rd  input  1  load request from the core datapath.
REQ-006 wr  input  1  store request from the core datapath.
REQ-007 addr  input  ADDR_W  byte address of the access.
REQ-008 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 wr_data  input  DATA_W  store data, right-aligned.
REQ-010 rd_data  output  DATA_W  load result, extended per funct3.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE; the core stalls on it.
REQ-012 done  output  1  one-cycle pulse when an access completes.
REQ-013 misalign  output  1  one-cycle pulse for a dropped misaligned access; present only with DMEM_MISALIGN_TRAP_EN.

Function
REQ-014 FSM states: IDLE, LD, RMW_RD, RMW_WR, ST.
REQ-015 Requests are sampled only in IDLE; rd/wr while busy is ignored.
REQ-016 rd and wr high together: treat as a store, drop the load.
REQ-017 Load: IDLE->LD (array read issued) ->IDLE; rd_data updated and done high in the cycle after LD; total latency is 2 clocks from acceptance.
REQ-018 Word store (funct3 010): IDLE->ST; the array is written and done is high in ST; ST->IDLE.
REQ-019 Byte/half store: IDLE->RMW_RD (read word) ->RMW_WR (merge lanes selected by addr[1:0], write) ->IDLE; done is high in RMW_WR.
REQ-020 Load extension: B/H sign-extend the selected lane; BU/HU zero-extend; W passes through.
REQ-021 Lane select: byte lane = addr[1:0]; half lane = addr[1]; word index = addr[ADDR_W-1:2].
REQ-022 Unlisted funct3 codes are handled as word accesses.
REQ-023 rd_data holds its value until the next load completes; stores do not change it.
REQ-024 Back-to-back: a new request is accepted in the first IDLE cycle after done; no accesses overlap.

Reset
REQ-025 On reset assertion, the FSM goes to IDLE and outputs are forced immediately: rd_data=0, busy=0, done=0, misalign=0.
REQ-026 Reset mid-access discards the pending write, and no done is issued; array contents are not cleared.

Configuration
REQ-027 With DMEM_MISALIGN_TRAP_EN defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, is not performed; misalign pulses for one cycle, FSM stays in IDLE, and no done is issued.
REQ-028 Without DMEM_MISALIGN_TRAP_EN: the misalign port is absent; the required low address bits are forced to zero and the access proceeds normally.

Structure
REQ-029 The shared package holds: funct3 encoding constants, the FSM state enum, and the default DATA_W/ADDR_W values.
REQ-030 One sub-module, dmem_array: synchronous-read, single-port word RAM with a whole-word write enable; the controller performs all lane merging.

Verification
REQ-031 Word store, then load: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rd_data=0xDEADBEEF, 2 clocks after acceptance.
REQ-032 Byte merge: word 0x11223344 at 0x020, SB addr 0x021 data 0xAA -> LW 0x020 returns 0x1122AA44; the SB done comes on the 2nd cycle after acceptance.
REQ-033 Extension: word 0x0000F080 at 0x030; LB 0x030 -> 0xFFFFFF80; LBU 0x030 -> 0x00000080; LH 0x030 -> 0xFFFFF080.
REQ-034 Simultaneous and busy handling: rd=wr=1 with SW 0x040 data 0x5 -> a store is performed and rd_data is unchanged; a second request issued while busy is ignored.
REQ-035 Reset mid-RMW: SB 0x051 data 0xFF, with reset low during RMW_WR -> no done; outputs are 0; word 0x050 is unchanged.
REQ-036 With the macro defined, LW 0x062 -> misalign pulse, no done, rd_data unchanged; without the macro, LW 0x062 returns the word at 0x060.
